seg7_capture_decoder: RTL and testbench
=======================================

Name: seg7_capture_decoder

Overview:
- Receive-side counterpart of the board's hex-to-7-segment display driver. Samples an active-low 7-segment pattern bus, such as a display loopback or a captured digit drive.
- Waits for the pattern to be stable, then decodes it back to a 4-bit hex value or a symbol class (dash, bars, blank).
- Delivers each new pattern once over a valid/ready handshake.
- Used for display self-test and for reading operands shown on segment outputs in the adder datapath.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples required before a pattern is accepted (legal range 1..255).
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  active-low segment pattern; bit0=a … bit6=g (0 = segment lit)
- sample_en  input  1  sample qualifier; seg_in is only sampled on edges where this is high
- out_ready  input  1  consumer accepts the held result
- clr_ovr  input  1  synchronous clear of the overrun flag
- out_valid  output  1  result held and pending
- hex_out  output  4  decoded hex digit, valid only when sym_out=00 and out_err=0
- sym_out  output  2  symbol class: 00 digit, 01 dash, 10 bars, 11 blank
- out_err  output  1  held pattern is not in the legal table
- overrun  output  1  sticky flag: a new stable pattern arrived while a result was pending

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, hex_out=0, sym_out=00, out_err=0, overrun=0.
  - Stability counter=0, sample register=7'b1111111, have_last=0, state=SETTLE.
  - A pending result is dropped.
- Sampling:
  - On each edge with sample_en=1, seg_in is registered.
  - If the new sample equals the previous sample, the counter increments and saturates at STABLE_CYCLES. Otherwise the counter loads 1.
  - sample_en=0 holds both the sample register and the counter.
- Stable means counter==STABLE_CYCLES.
- Decode table (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Symbols: dash=0111111 (01), bars=0110110 (10), blank=1111111 (11).
  - Any other pattern: out_err=1, hex_out=0, sym_out=00.
- State machine, 2 states:
  - SETTLE:
    - When stable and (have_last=0 or sample≠last_emitted), latch the decoded outputs, set last_emitted=sample and have_last=1, then go to HOLD.
    - out_valid rises on the edge after the STABLE_CYCLES-th identical sample, giving latency STABLE_CYCLES+1 edges from the first sample.
  - HOLD:
    - out_valid=1. Outputs are frozen until the edge where out_ready=1, then out_valid=0 and the state returns to SETTLE.
    - Sampling and counting continue during HOLD.
    - If a stable pattern ≠ held pattern is reached during HOLD, overrun is set; intermediate patterns are lost.
    - After return to SETTLE, the currently stable pattern is emitted on the next edge if it differs from last_emitted. Only the newest pattern is delivered.
- An identical pattern is never re-emitted, regardless of how long it persists or whether sample_en toggles.
- out_ready while out_valid=0 is ignored.
- The earliest re-emission after a handshake is one edge later; back-to-back valid is never produced on the handshake edge.
- overrun set and clr_ovr on the same edge: set wins.
- Reset mid-HOLD clears everything. The first stable pattern after reset is always emitted, blank included.

Test Plan:
- Reset, then hold seg_in=1111001 with sample_en=1 and out_ready=1 → out_valid high exactly 5 edges after the first sample (STABLE_CYCLES=4), hex_out=1, sym_out=00, out_err=0, then one pulse only.
- Glitch: 0100100 for 2 cycles, 0110000 for 1 cycle, then 0000000 held → single emission hex_out=8; no emission of 2 or 3.
- Symbols and illegal: apply 0111111, 0110110, 1111111, 1010101 in turn, each held 6 cycles, out_ready=1 → sym_out 01, 10, 11, then out_err=1 with hex_out=0.
- Backpressure: out_ready=0; stable 0001000 (A), then stable 0000011 (b), then stable 1000110 (C); raise out_ready → first read A with overrun=1; next emission C, b never seen; clr_ovr → overrun=0.
- sample_en gating: stable digit 5 with sample_en pulsed high every other cycle → valid only after 4 qualified samples; toggling sample_en on the same pattern causes no re-emission.
- Async reset asserted mid-HOLD with out_valid=1 → all outputs 0 immediately; the same pattern still on seg_in is re-emitted after STABLE_CYCLES+1 edges.

Source files
------------

// File: rtl/seg7_capture_decoder_if.sv
// Result channel of the 7-segment capture decoder.
// Handshake: the producer raises out_valid with hex_out/sym_out/out_err
// stable; they stay frozen until a rising clock edge where out_ready=1,
// which completes the transfer. out_ready is ignored while out_valid=0.
interface seg7_capture_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] hex_out;
    logic [1:0] sym_out;
    logic       out_err;

    modport master (
        output out_valid,
        output hex_out,
        output sym_out,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  hex_out,
        input  sym_out,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Samples an active-low 7-segment bus, waits for it to be stable and
// delivers each new pattern once, decoded to a hex digit or symbol class.
module seg7_capture_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    seg_in,
    input  logic                          sample_en,
    input  logic                          clr_ovr,
    output logic                          overrun,
    output logic                          dbg_state,
    seg7_capture_decoder_if.master        out_if
);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

    // Returns {err, sym[1:0], hex[3:0]} for an active-low g..a pattern.
    function automatic logic [6:0] decode(input logic [6:0] p);
        logic [6:0] r;
        case (p)
            7'b1000000: r = {1'b0, 2'b00, 4'h0};
            7'b1111001: r = {1'b0, 2'b00, 4'h1};
            7'b0100100: r = {1'b0, 2'b00, 4'h2};
            7'b0110000: r = {1'b0, 2'b00, 4'h3};
            7'b0011001: r = {1'b0, 2'b00, 4'h4};
            7'b0010010: r = {1'b0, 2'b00, 4'h5};
            7'b0000010: r = {1'b0, 2'b00, 4'h6};
            7'b1111000: r = {1'b0, 2'b00, 4'h7};
            7'b0000000: r = {1'b0, 2'b00, 4'h8};
            7'b0010000: r = {1'b0, 2'b00, 4'h9};
            7'b0001000: r = {1'b0, 2'b00, 4'hA};
            7'b0000011: r = {1'b0, 2'b00, 4'hB};
            7'b1000110: r = {1'b0, 2'b00, 4'hC};
            7'b0100001: r = {1'b0, 2'b00, 4'hD};
            7'b0000110: r = {1'b0, 2'b00, 4'hE};
            7'b0001110: r = {1'b0, 2'b00, 4'hF};
            7'b0111111: r = {1'b0, 2'b01, 4'h0};
            7'b0110110: r = {1'b0, 2'b10, 4'h0};
            7'b1111111: r = {1'b0, 2'b11, 4'h0};
            default:    r = {1'b1, 2'b00, 4'h0};
        endcase
        return r;
    endfunction

    state_t           state_q;
    logic [6:0]       sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       last_q;
    logic             have_last_q;
    logic             valid_q;
    logic [3:0]       hex_q;
    logic [1:0]       sym_q;
    logic             err_q;
    logic             ovr_q;

    logic             stable;
    logic             is_new;
    logic             ovr_set;
    logic [6:0]       dec;

    // Next sample/run length: qualified samples only, run saturates at STABLE_N.
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        if (sample_en) begin
            sample_d = seg_in;
            if (seg_in != sample_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != STABLE_N) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable  = (cnt_q == STABLE_N);
    assign is_new  = !have_last_q || (sample_q != last_q);
    assign ovr_set = (state_q == ST_HOLD) && stable && (sample_q != last_q);
    assign dec     = decode(sample_q);

    // Sample register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= 7'b1111111;
            cnt_q    <= '0;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
        end
    end

    // Delivery FSM with registered result, dedup memory and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SETTLE;
            valid_q     <= 1'b0;
            hex_q       <= 4'h0;
            sym_q       <= 2'b00;
            err_q       <= 1'b0;
            last_q      <= 7'b0;
            have_last_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (stable && is_new) begin
                        err_q       <= dec[6];
                        sym_q       <= dec[5:4];
                        hex_q       <= dec[3:0];
                        last_q      <= sample_q;
                        have_last_q <= 1'b1;
                        valid_q     <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_if.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_SETTLE;
                    end
                end
                default: state_q <= ST_SETTLE;
            endcase
            // A new stable pattern while holding beats a same-edge clear.
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.hex_out   = hex_q;
    assign out_if.sym_out   = sym_q;
    assign out_if.out_err   = err_q;
    assign overrun          = ovr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_seg7_capture_decoder;
    localparam int S = 4;

    localparam logic [6:0] PAT_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] P_DASH  = 7'b0111111;
    localparam logic [6:0] P_BARS  = 7'b0110110;
    localparam logic [6:0] P_BLANK = 7'b1111111;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       sample_en;
    logic       clr_ovr;
    logic       out_ready;
    logic       overrun;
    logic       dbg_state;

    always #5 clk = ~clk;

    seg7_capture_decoder_if u_if ();
    assign u_if.out_ready = out_ready;

    seg7_capture_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .sample_en (sample_en),
        .clr_ovr   (clr_ovr),
        .overrun   (overrun),
        .dbg_state (dbg_state),
        .out_if    (u_if.master)
    );

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] m_hist[$];   // last S qualified samples
    bit         m_pend;
    bit         m_have;
    bit         m_ovr;
    logic [6:0] m_held;
    logic [6:0] m_last;
    bit         prev_v;
    int         lg_hex[$];
    int         lg_sym[$];
    int         lg_err[$];

    // {err, sym, hex} by table lookup.
    function automatic logic [6:0] ref_decode(input logic [6:0] p);
        logic [6:0] r;
        r = {1'b1, 2'b00, 4'h0};
        for (int i = 0; i < 16; i++)
            if (p == PAT_TAB[i]) r = {1'b0, 2'b00, 4'(i)};
        if (p == P_DASH)  r = {1'b0, 2'b01, 4'h0};
        if (p == P_BARS)  r = {1'b0, 2'b10, 4'h0};
        if (p == P_BLANK) r = {1'b0, 2'b11, 4'h0};
        return r;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_pend = 0;
        m_have = 0;
        m_ovr  = 0;
        m_held = '0;
        m_last = '0;
        prev_v = 0;
    endtask

    // Advance the model by one rising edge using the pre-edge inputs.
    task automatic model_step();
        bit         st;
        bit         setv;
        logic [6:0] cur;
        st = 0; setv = 0; cur = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_hist.size() == S) begin
            cur = m_hist[S-1];
            st  = 1;
            foreach (m_hist[i]) if (m_hist[i] != cur) st = 0;
        end
        if (m_pend) begin
            if (st && cur != m_held) setv = 1;
            if (out_ready) m_pend = 0;
        end else if (st && (!m_have || cur != m_last)) begin
            m_pend = 1;
            m_held = cur;
            m_last = cur;
            m_have = 1;
        end
        if (setv) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (sample_en) begin
            m_hist.push_back(seg_in);
            if (m_hist.size() > S) void'(m_hist.pop_front());
        end
    endtask

    // Compare DUT against model; log each rising out_valid.
    task automatic compare();
        logic [6:0] e;
        chk("out_valid", 32'(u_if.out_valid), 32'(m_pend));
        chk("dbg_state", 32'(dbg_state), 32'(m_pend));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_pend) begin
            e = ref_decode(m_held);
            chk("hex_out", 32'(u_if.hex_out), 32'(e[3:0]));
            chk("sym_out", 32'(u_if.sym_out), 32'(e[5:4]));
            chk("out_err", 32'(u_if.out_err), 32'(e[6]));
        end
        if (u_if.out_valid && !prev_v) begin
            lg_hex.push_back(int'(u_if.hex_out));
            lg_sym.push_back(int'(u_if.sym_out));
            lg_err.push_back(int'(u_if.out_err));
        end
        prev_v = u_if.out_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) tick();
    endtask

    task automatic clear_log();
        lg_hex.delete();
        lg_sym.delete();
        lg_err.delete();
    endtask

    // Ticks until out_valid is seen, -1 if the budget expires.
    task automatic wait_valid(output int lat, input int budget);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (u_if.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int run;
        logic [6:0] cur_p;

        rst_n = 1'b0; seg_in = 7'b1111111; sample_en = 1'b0;
        clr_ovr = 1'b0; out_ready = 1'b0;
        model_reset();
        clear_log();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_hex", 32'(u_if.hex_out), 32'd0);
        chk("rst_sym", 32'(u_if.sym_out), 32'd0);
        chk("rst_err", 32'(u_if.out_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady digit 1: valid 5 edges after the first sample, one pulse.
        seg_in = 7'b1111001; sample_en = 1'b1; out_ready = 1'b1;
        wait_valid(lat, 20);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_hex", 32'(u_if.hex_out), 32'd1);
        chk("t1_sym", 32'(u_if.sym_out), 32'd0);
        chk("t1_err", 32'(u_if.out_err), 32'd0);
        repeat (10) tick();
        chk("t1_pulses", 32'(lg_hex.size()), 32'd1);

        // Glitches 2,3 then 8 held: only 8 delivered.
        clear_log();
        hold(7'b0100100, 2);
        hold(7'b0110000, 1);
        hold(7'b0000000, 8);
        chk("t2_count", 32'(lg_hex.size()), 32'd1);
        chk("t2_hex", 32'(lg_hex[0]), 32'd8);

        // Symbols and an illegal pattern.
        clear_log();
        hold(P_DASH, 6);
        hold(P_BARS, 6);
        hold(P_BLANK, 6);
        hold(7'b1010101, 6);
        chk("t3_count", 32'(lg_sym.size()), 32'd4);
        chk("t3_dash", 32'(lg_sym[0]), 32'd1);
        chk("t3_bars", 32'(lg_sym[1]), 32'd2);
        chk("t3_blank", 32'(lg_sym[2]), 32'd3);
        chk("t3_ill_err", 32'(lg_err[3]), 32'd1);
        chk("t3_ill_hex", 32'(lg_hex[3]), 32'd0);

        // Backpressure: A held, b lost, C delivered next, overrun raised.
        clear_log();
        out_ready = 1'b0;
        hold(7'b0001000, 6);
        hold(7'b0000011, 6);
        hold(7'b1000110, 6);
        chk("t4_valid", 32'(u_if.out_valid), 32'd1);
        chk("t4_hex_a", 32'(u_if.hex_out), 32'd10);
        chk("t4_ovr", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        hold(7'b1000110, 6);
        chk("t4_count", 32'(lg_hex.size()), 32'd2);
        chk("t4_first", 32'(lg_hex[0]), 32'd10);
        chk("t4_second", 32'(lg_hex[1]), 32'd12);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'd0);

        // sample_en every other cycle: 4 qualified samples then emit once.
        clear_log();
        seg_in = 7'b0010010;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            sample_en = (i % 2 == 0);
            tick();
            if (u_if.out_valid) begin
                lat = i + 1;
                break;
            end
        end
        chk("t5_latency", 32'(lat), 32'd8);
        chk("t5_hex", 32'(u_if.hex_out), 32'd5);
        for (int i = 0; i < 12; i++) begin
            sample_en = (i % 2 == 0);
            tick();
        end
        chk("t5_count", 32'(lg_hex.size()), 32'd1);
        sample_en = 1'b1;

        // Async reset mid-HOLD, same pattern re-emitted afterwards.
        clear_log();
        out_ready = 1'b0;
        hold(7'b1000000, 6);
        chk("t6_held", 32'(u_if.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(u_if.out_valid), 32'd0);
        chk("t6_rst_hex", 32'(u_if.hex_out), 32'd0);
        chk("t6_rst_sym", 32'(u_if.sym_out), 32'd0);
        chk("t6_rst_err", 32'(u_if.out_err), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_valid(lat, 20);
        chk("t6_latency", 32'(lat), 32'd5);
        chk("t6_hex", 32'(u_if.hex_out), 32'd0);

        // Randomized traffic against the model.
        run = 0;
        cur_p = 7'b1111111;
        for (int n = 0; n < 3000; n++) begin
            if (run == 0) begin
                case ($urandom_range(0, 5))
                    0: cur_p = P_DASH;
                    1: cur_p = P_BARS;
                    2: cur_p = P_BLANK;
                    3: cur_p = 7'($urandom_range(0, 127));
                    default: cur_p = PAT_TAB[$urandom_range(0, 15)];
                endcase
                run = $urandom_range(1, 9);
            end
            run--;
            seg_in    = cur_p;
            sample_en = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clr_ovr   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
